// File: rtl/int_acceptor.sv
// Interrupt acceptance stage: latches a device request, owns the 8080 INTE flip-flop
// (delayed EI, immediate DI) and hands the captured instruction to fetch, then pulses INTA.
module int_acceptor #(
    parameter int unsigned INSTR_W    = 24,
    parameter int unsigned DROP_W     = 8,
    parameter logic        RESET_INTE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               interrupt,
    input  logic [INSTR_W-1:0] interrupt_instruction,
    input  logic               ei_exec,
    input  logic               di_exec,
    input  logic               instr_boundary,
    input  logic               inject_ack,
    output logic               inte,
    output logic               int_pending,
    output logic               inject_valid,
    output logic [INSTR_W-1:0] inject_instr,
    output logic               inta,
    output logic               wake,
    output logic [DROP_W-1:0]  drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        INJ  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_inte;
    logic               w_inte_nxt;
    logic               r_ei_armed;
    logic               w_ei_armed_nxt;
    logic               r_inta;
    logic               w_inta_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic [DROP_W-1:0]  r_drop;
    logic [DROP_W-1:0]  w_drop_nxt;
    logic               w_accept;
    logic               w_drop_evt;
    logic               w_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_inte     <= RESET_INTE;
            r_ei_armed <= 1'b0;
            r_inta     <= 1'b0;
            r_instr    <= '0;
            r_drop     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inte     <= w_inte_nxt;
            r_ei_armed <= w_ei_armed_nxt;
            r_inta     <= w_inta_nxt;
            r_instr    <= w_instr_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_inte_nxt     = r_inte;
        w_ei_armed_nxt = r_ei_armed;
        w_inta_nxt     = 1'b0;
        w_instr_nxt    = r_instr;
        w_drop_nxt     = r_drop;
        w_accept       = 1'b0;
        w_drop_evt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (interrupt) begin
                    w_state_nxt = PEND;
                    w_instr_nxt = interrupt_instruction;
                end
            end
            PEND: begin
                // DI in the same cycle vetoes acceptance.
                if (r_inte && instr_boundary && !di_exec) begin
                    w_accept    = 1'b1;
                    w_state_nxt = INJ;
                end
                if (interrupt) begin
                    w_drop_evt = 1'b1;
                end
            end
            INJ: begin
                if (inject_ack) begin
                    w_inta_nxt = 1'b1;
                    if (interrupt) begin
                        w_state_nxt = PEND;
                        w_instr_nxt = interrupt_instruction;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (interrupt) begin
                    w_drop_evt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Priority, lowest first: delayed EI takes effect, EI arms, acceptance, DI.
        if (r_ei_armed && instr_boundary) begin
            w_inte_nxt     = 1'b1;
            w_ei_armed_nxt = 1'b0;
        end
        if (ei_exec) begin
            w_ei_armed_nxt = 1'b1;
        end
        if (w_accept || di_exec) begin
            w_inte_nxt     = 1'b0;
            w_ei_armed_nxt = 1'b0;
        end

        if (w_drop_evt && (r_drop != '1)) begin
            w_drop_nxt = r_drop + DROP_W'(1);
        end
    end

    assign w_pending    = (r_state != IDLE);
    assign inte         = r_inte;
    assign int_pending  = w_pending;
    assign inject_valid = (r_state == INJ);
    assign inject_instr = r_instr;
    assign inta         = r_inta;
    assign wake         = w_pending & r_inte;
    assign drop_count   = r_drop;

endmodule

// File: tb/tb_int_acceptor.sv
// Directed and randomized checks of int_acceptor against a queue-based behavioural model.
module tb_int_acceptor;

    logic        clk;
    logic        rst;
    logic        interrupt;
    logic [23:0] interrupt_instruction;
    logic        ei_exec;
    logic        di_exec;
    logic        instr_boundary;
    logic        inject_ack;
    logic        inte;
    logic        int_pending;
    logic        inject_valid;
    logic [23:0] inject_instr;
    logic        inta;
    logic        wake;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_errors = 0;

    // Model: the request slot holds at most one instruction.
    logic [23:0] m_slot[$];
    logic [23:0] m_last;
    bit          m_injecting;
    bit          m_inte;
    bit          m_armed;
    bit          m_inta;
    int          m_drops;

    int_acceptor #(
        .INSTR_W    (24),
        .DROP_W     (8),
        .RESET_INTE (1'b0)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .interrupt             (interrupt),
        .interrupt_instruction (interrupt_instruction),
        .ei_exec               (ei_exec),
        .di_exec               (di_exec),
        .instr_boundary        (instr_boundary),
        .inject_ack            (inject_ack),
        .inte                  (inte),
        .int_pending           (int_pending),
        .inject_valid          (inject_valid),
        .inject_instr          (inject_instr),
        .inta                  (inta),
        .wake                  (wake),
        .drop_count            (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot.delete();
        m_last      = '0;
        m_injecting = 0;
        m_inte      = 0;
        m_armed     = 0;
        m_inta      = 0;
        m_drops     = 0;
    endtask

    task automatic model_update();
        bit full;
        bit accept;
        bit acked;
        bit free_now;
        full     = (m_slot.size() != 0);
        accept   = full && !m_injecting && m_inte && (instr_boundary === 1'b1) && (di_exec !== 1'b1);
        acked    = m_injecting && (inject_ack === 1'b1);
        free_now = !full || acked;
        m_inta   = acked;
        if (acked) begin
            void'(m_slot.pop_front());
            m_injecting = 0;
        end
        if (interrupt === 1'b1) begin
            if (free_now) begin
                m_slot.push_back(interrupt_instruction);
                m_last = interrupt_instruction;
            end else begin
                m_drops++;
            end
        end
        if (accept) m_injecting = 1;
        if (m_armed && (instr_boundary === 1'b1)) begin
            m_inte  = 1;
            m_armed = 0;
        end
        if (ei_exec === 1'b1) m_armed = 1;
        if (accept || (di_exec === 1'b1)) begin
            m_inte  = 0;
            m_armed = 0;
        end
    endtask

    task automatic check_all();
        chk("inte",         32'(inte),         32'(m_inte));
        chk("int_pending",  32'(int_pending),  32'(m_slot.size() != 0));
        chk("inject_valid", 32'(inject_valid), 32'(m_injecting));
        chk("inject_instr", 32'(inject_instr), 32'(m_last));
        chk("inta",         32'(inta),         32'(m_inta));
        chk("wake",         32'(wake),         32'((m_slot.size() != 0) && m_inte));
        chk("drop_count",   32'(drop_count),   32'((m_drops > 255) ? 255 : m_drops));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_update();
        #1;
        check_all();
    endtask

    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, "_inte"},   32'(inte),         32'd0);
        chk({tag, "_pend"},   32'(int_pending),  32'd0);
        chk({tag, "_valid"},  32'(inject_valid), 32'd0);
        chk({tag, "_instr"},  32'(inject_instr), 32'd0);
        chk({tag, "_inta"},   32'(inta),         32'd0);
        chk({tag, "_wake"},   32'(wake),         32'd0);
        chk({tag, "_drops"},  32'(drop_count),   32'd0);
        step();
        step();
        chk({tag, "_held_valid"}, 32'(inject_valid), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [23:0] a;
        logic [23:0] x;
        rst = 1'b0;
        interrupt = 1'b0;
        interrupt_instruction = '0;
        ei_exec = 1'b0;
        di_exec = 1'b0;
        instr_boundary = 1'b0;
        inject_ack = 1'b0;
        model_reset();

        // T1: asynchronous reset mid-cycle
        async_reset("t1");
        step();

        // T2: basic EI, request, injection, acknowledge
        ei_exec = 1'b1; step(); ei_exec = 1'b0;
        step();
        instr_boundary = 1'b1; step(); instr_boundary = 1'b0;
        chk("t2_inte_on", 32'(inte), 32'd1);
        step(); step(); step();
        instr_boundary = 1'b1; step(); instr_boundary = 1'b0;
        chk("t2_idle", 32'(int_pending), 32'd0);
        interrupt = 1'b1; interrupt_instruction = 24'hFF0000; step(); interrupt = 1'b0;
        chk("t2_pending", 32'(int_pending), 32'd1);
        chk("t2_not_valid", 32'(inject_valid), 32'd0);
        chk("t2_wake", 32'(wake), 32'd1);
        instr_boundary = 1'b1; step(); instr_boundary = 1'b0;
        chk("t2_valid", 32'(inject_valid), 32'd1);
        chk("t2_inte_off", 32'(inte), 32'd0);
        chk("t2_instr", 32'(inject_instr), 32'hFF0000);
        step();
        chk("t2_no_inta_early", 32'(inta), 32'd0);
        inject_ack = 1'b1; step(); inject_ack = 1'b0;
        chk("t2_inta", 32'(inta), 32'd1);
        chk("t2_cleared", 32'(int_pending), 32'd0);
        step();
        chk("t2_inta_once", 32'(inta), 32'd0);

        // T3: request held while disabled, then delayed EI
        interrupt = 1'b1; interrupt_instruction = 24'hCF0000; step(); interrupt = 1'b0;
        instr_boundary = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t3_pend", 32'(int_pending), 32'd1);
            chk("t3_no_inj", 32'(inject_valid), 32'd0);
            chk("t3_no_wake", 32'(wake), 32'd0);
        end
        instr_boundary = 1'b0;
        ei_exec = 1'b1; step(); ei_exec = 1'b0;
        instr_boundary = 1'b1; step(); instr_boundary = 1'b0;
        chk("t3_first_bnd_no_inj", 32'(inject_valid), 32'd0);
        chk("t3_inte_on", 32'(inte), 32'd1);
        step();
        instr_boundary = 1'b1; step(); instr_boundary = 1'b0;
        chk("t3_inj", 32'(inject_valid), 32'd1);
        chk("t3_instr", 32'(inject_instr), 32'hCF0000);
        inject_ack = 1'b1; step(); inject_ack = 1'b0;

        // T4: drops while pending, then saturation while injecting
        a = 24'($urandom);
        interrupt = 1'b1;
        interrupt_instruction = a; step();
        interrupt_instruction = 24'($urandom); step();
        interrupt_instruction = 24'($urandom); step();
        interrupt = 1'b0;
        chk("t4_instr_a", 32'(inject_instr), 32'(a));
        chk("t4_drops2", 32'(drop_count), 32'd2);
        ei_exec = 1'b1; step(); ei_exec = 1'b0;
        instr_boundary = 1'b1; step(); step(); instr_boundary = 1'b0;
        chk("t4_inj", 32'(inject_valid), 32'd1);
        interrupt = 1'b1;
        for (int i = 0; i < 300; i++) begin
            interrupt_instruction = 24'($urandom);
            step();
        end
        interrupt = 1'b0;
        chk("t4_sat", 32'(drop_count), 32'hFF);
        chk("t4_instr_frozen", 32'(inject_instr), 32'(a));
        inject_ack = 1'b1; step(); inject_ack = 1'b0;

        // T5: ack with coincident request, EI+DI, DI at accepting boundary
        ei_exec = 1'b1; step(); ei_exec = 1'b0;
        instr_boundary = 1'b1; step(); instr_boundary = 1'b0;
        x = 24'($urandom);
        interrupt = 1'b1; interrupt_instruction = x; step(); interrupt = 1'b0;
        instr_boundary = 1'b1; step(); instr_boundary = 1'b0;
        chk("t5_inj", 32'(inject_valid), 32'd1);
        inject_ack = 1'b1; interrupt = 1'b1; interrupt_instruction = 24'hD70000; step();
        inject_ack = 1'b0; interrupt = 1'b0;
        chk("t5_inta", 32'(inta), 32'd1);
        chk("t5_pend", 32'(int_pending), 32'd1);
        chk("t5_not_inj", 32'(inject_valid), 32'd0);
        chk("t5_instr", 32'(inject_instr), 32'hD70000);
        chk("t5_no_drop", 32'(drop_count), 32'hFF);
        ei_exec = 1'b1; di_exec = 1'b1; step(); ei_exec = 1'b0; di_exec = 1'b0;
        instr_boundary = 1'b1; step(); step(); instr_boundary = 1'b0;
        chk("t5_eidi_inte", 32'(inte), 32'd0);
        chk("t5_eidi_noinj", 32'(inject_valid), 32'd0);
        ei_exec = 1'b1; step(); ei_exec = 1'b0;
        instr_boundary = 1'b1; step();
        chk("t5_inte_on", 32'(inte), 32'd1);
        di_exec = 1'b1; step(); di_exec = 1'b0; instr_boundary = 1'b0;
        chk("t5_di_noinj", 32'(inject_valid), 32'd0);
        chk("t5_di_inte", 32'(inte), 32'd0);
        chk("t5_di_pend", 32'(int_pending), 32'd1);

        // T6: reset while injecting
        ei_exec = 1'b1; step(); ei_exec = 1'b0;
        instr_boundary = 1'b1; step(); step(); instr_boundary = 1'b0;
        chk("t6_inj", 32'(inject_valid), 32'd1);
        async_reset("t6");
        inject_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_no_inta", 32'(inta), 32'd0);
        end
        inject_ack = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            interrupt             = ($urandom_range(0, 99) < 20);
            interrupt_instruction = 24'($urandom);
            ei_exec               = ($urandom_range(0, 99) < 10);
            di_exec               = ($urandom_range(0, 99) < 4);
            instr_boundary        = ($urandom_range(0, 99) < 35);
            inject_ack            = ($urandom_range(0, 99) < 40);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
